// File: rtl/stream_demux.sv
// stream_demux: 1-to-N registered stream demultiplexer with a one-entry buffer.
// A beat accepted at edge n appears on its lane in cycle n+1. Back-to-back beats are
// reloaded on the same edge the lane accepts, so throughput is one beat per clock.
// A beat whose select is out of range is dropped and flagged with a one-cycle err_sel pulse.
// Optional feature: define DEMUX_PKT_LOCK_EN to add in_last/out_last and lock the lane
// for the duration of a packet.
module stream_demux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_sel
`ifdef DEMUX_PKT_LOCK_EN
  ,
  input  logic                    in_last,
  output logic [N_OUT-1:0]        out_last
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [SEL_W-1:0]  hold_sel_q;
  logic              err_sel_q;

`ifdef DEMUX_PKT_LOCK_EN
  logic              hold_last_q;
  logic              pkt_busy_q;  // inside a packet, lane already latched
  logic [SEL_W-1:0]  pkt_sel_q;
  logic              pkt_drop_q;  // current packet started with a bad select
`endif

  logic             lane_ready;
  logic             accept;
  logic             sel_ok;
  logic [SEL_W-1:0] eff_sel;
  logic             eff_drop;
  logic             new_err;

  // Ready of the lane currently holding the buffered beat.
  always_comb begin
    lane_ready = 1'b0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (hold_sel_q == SEL_W'(k)) lane_ready = out_ready[k];
    end
  end

  assign in_ready = !rst && ((state_q == StEmpty) || lane_ready);
  assign accept   = in_valid && in_ready;
  assign sel_ok   = 32'(in_sel) < N_OUT;

  // Routing decision for the incoming beat; a locked packet overrides in_sel.
  always_comb begin
    eff_sel  = in_sel;
    eff_drop = !sel_ok;
    new_err  = !sel_ok;
`ifdef DEMUX_PKT_LOCK_EN
    if (pkt_busy_q) begin
      eff_sel  = pkt_sel_q;
      eff_drop = pkt_drop_q;
      new_err  = 1'b0;
    end
`endif
  end

  // Buffer FSM: load on accept, drain when the selected lane takes the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      err_sel_q   <= 1'b0;
`ifdef DEMUX_PKT_LOCK_EN
      hold_last_q <= 1'b0;
      pkt_busy_q  <= 1'b0;
      pkt_sel_q   <= '0;
      pkt_drop_q  <= 1'b0;
`endif
    end else begin
      err_sel_q <= accept && new_err;
      if (accept) begin
        // in_ready in StFull implies the held beat leaves on this same edge.
        if (eff_drop) begin
          state_q <= StEmpty;
        end else begin
          state_q     <= StFull;
          hold_data_q <= in_data;
          hold_sel_q  <= eff_sel;
`ifdef DEMUX_PKT_LOCK_EN
          hold_last_q <= in_last;
`endif
        end
`ifdef DEMUX_PKT_LOCK_EN
        pkt_busy_q <= !in_last;
        pkt_sel_q  <= eff_sel;
        pkt_drop_q <= eff_drop;
`endif
      end else if (state_q == StFull && lane_ready) begin
        state_q <= StEmpty;
      end
    end
  end

  // Lane outputs: only the held lane is valid, all other lanes are driven to zero.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
`ifdef DEMUX_PKT_LOCK_EN
    out_last  = '0;
`endif
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (state_q == StFull && hold_sel_q == SEL_W'(k)) begin
        out_valid[k]                = 1'b1;
        out_data[k*DATA_W +: DATA_W] = hold_data_q;
`ifdef DEMUX_PKT_LOCK_EN
        out_last[k]                 = hold_last_q;
`endif
      end
    end
  end

  assign err_sel = err_sel_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-lane instance checked through a scoreboard queue and a
// 3-lane instance used for out-of-range select behaviour.
module tb_stream_demux;

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;
  logic        in_last_v;
`ifdef DEMUX_PKT_LOCK_EN
  logic [3:0]  out_last;
`endif

  logic [7:0]  d3_in_data;
  logic [1:0]  d3_in_sel;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [2:0]  d3_out_ready;
  logic        d3_err_sel;
`ifdef DEMUX_PKT_LOCK_EN
  logic        d3_in_last;
  logic [2:0]  d3_out_last;
`endif

  int   checks;
  int   passes;
  exp_t sb[$];

  stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel)
`ifdef DEMUX_PKT_LOCK_EN
    ,
    .in_last   (in_last_v),
    .out_last  (out_last)
`endif
  );

  stream_demux #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d3_in_data),
    .in_sel    (d3_in_sel),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .out_data  (d3_out_data),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .err_sel   (d3_err_sel)
`ifdef DEMUX_PKT_LOCK_EN
    ,
    .in_last   (d3_in_last),
    .out_last  (d3_out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every lane handshake must match the oldest expected beat.
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] ed;
    exp_t        e;
    if (!rst && (out_valid & out_ready) != 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: out_valid=%b out_data=%h, required no beat", out_valid,
                 out_data);
      end else begin
        e  = sb.pop_front();
        ev = 4'b0001 << e.lane;
        ed = '0;
        ed[e.lane*8 +: 8] = e.data;
`ifdef DEMUX_PKT_LOCK_EN
        if (out_valid !== ev || out_data !== ed || out_last !== (e.last ? ev : 4'b0)) begin
          $display("FAIL sb_beat: valid=%b data=%h last=%b, required valid=%b data=%h last=%b",
                   out_valid, out_data, out_last, ev, ed, e.last ? ev : 4'b0);
        end else passes++;
`else
        if (out_valid !== ev || out_data !== ed) begin
          $display("FAIL sb_beat: valid=%b data=%h, required valid=%b data=%h",
                   out_valid, out_data, ev, ed);
        end else passes++;
`endif
      end
    end
  end

  // Present one beat on the 4-lane instance and hold it until accepted.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic last,
                      input int exp_lane);
    exp_t e;
    bit   acc;
    int   n;
    in_data   = d;
    in_sel    = s;
    in_last_v = last;
    in_valid  = 1'b1;
    if (exp_lane >= 0) begin
      e.lane = exp_lane;
      e.data = d;
      e.last = last;
      sb.push_back(e);
    end
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    in_last_v = 1'b0;
    checks++;
    if (!acc) $display("FAIL send_timeout: in_ready=%b, required 1 within 50 clk", in_ready);
    else passes++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL %s_drain: %0d beats left, required 0", name, sb.size());
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0 || out_data !== 32'b0 || err_sel !== 1'b0)
      $display("FAIL reset_outputs: valid=%b data=%h err=%b, required 0 0 0",
               out_valid, out_data, err_sel);
    else passes++;
    checks++;
    if (d3_out_valid !== 3'b0 || d3_err_sel !== 1'b0)
      $display("FAIL reset_dut3: valid=%b err=%b, required 0 0", d3_out_valid, d3_err_sel);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    else passes++;
  endtask

  task automatic test_stream();
    logic [1:0] sels[3];
    logic [7:0] dats[3];
    sels = '{2'd0, 2'd3, 2'd1};
    dats = '{8'h11, 8'h22, 8'h33};
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      send(dats[i], sels[i], 1'b0, int'(sels[i]));
      checks++;
      if (out_valid !== (4'b0001 << sels[i]) || out_data[sels[i]*8 +: 8] !== dats[i])
        $display("FAIL stream_beat%0d: valid=%b data=%h, required valid=%b lane data=%h",
                 i, out_valid, out_data, 4'b0001 << sels[i], dats[i]);
      else passes++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0) $display("FAIL stream_idle: valid=%b, required 0000", out_valid);
    else passes++;
    drain("stream");
  endtask

  task automatic test_stall();
    exp_t e;
    out_ready = 4'b1011;
    send(8'hA5, 2'd2, 1'b0, 2);
    in_data  = 8'h5A;
    in_sel   = 2'd0;
    in_valid = 1'b1;
    e.lane = 0;
    e.data = 8'h5A;
    e.last = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 4'b0100 || out_data !== 32'h00A5_0000 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d: valid=%b data=%h ready=%b, required 0100 00a50000 0",
                 i, out_valid, out_data, in_ready);
      else passes++;
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b, required 1", in_ready);
    else passes++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0001 || out_data !== 32'h0000_005A)
      $display("FAIL stall_b2b: valid=%b data=%h, required 0001 0000005a", out_valid, out_data);
    else passes++;
    drain("stall");
  endtask

  task automatic test_bad_sel();
    d3_out_ready = 3'b111;
    d3_in_data   = 8'h77;
    d3_in_sel    = 2'd3;
    d3_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    d3_in_valid = 1'b0;
    checks++;
    if (d3_out_valid !== 3'b0 || d3_err_sel !== 1'b1)
      $display("FAIL badsel_pulse: valid=%b err=%b, required 000 1", d3_out_valid, d3_err_sel);
    else passes++;
    d3_in_data  = 8'h01;
    d3_in_sel   = 2'd2;
    d3_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d3_in_valid = 1'b0;
    checks++;
    if (d3_err_sel !== 1'b0) $display("FAIL badsel_once: err=%b, required 0", d3_err_sel);
    else passes++;
    checks++;
    if (d3_out_valid !== 3'b100 || d3_out_data !== 24'h01_0000)
      $display("FAIL badsel_next: valid=%b data=%h, required 100 010000",
               d3_out_valid, d3_out_data);
    else passes++;
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b1101;
    send(8'h44, 2'd1, 1'b0, -1);
    checks++;
    if (out_valid !== 4'b0010) $display("FAIL rstmid_held: valid=%b, required 0010", out_valid);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0 || out_data !== 32'b0)
      $display("FAIL rstmid_clear: valid=%b data=%h, required 0 0", out_valid, out_data);
    else passes++;
    rst = 1'b0;
    out_ready = 4'hF;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0) $display("FAIL rstmid_lost: valid=%b, required 0000", out_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] s;
    out_ready = 4'hF;
    for (int i = 0; i < 12; i++) begin
      s = 2'($urandom_range(0, 3));
      send(8'(i * 13 + 7), s, 1'b0, int'(s));
      checks++;
      if (out_valid !== (4'b0001 << s))
        $display("FAIL b2b_lane%0d: valid=%b, required %b", i, out_valid, 4'b0001 << s);
      else passes++;
    end
    drain("b2b");
  endtask

`ifdef DEMUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    out_ready = 4'hF;
    send(8'hB0, 2'd2, 1'b0, 2);
    send(8'hB1, 2'd0, 1'b0, 2);
    send(8'hB2, 2'd1, 1'b1, 2);
    send(8'hC0, 2'd3, 1'b1, 3);
    drain("pkt");
  endtask
`endif

  initial begin
    checks       = 0;
    passes       = 0;
    rst          = 1'b1;
    in_data      = '0;
    in_sel       = '0;
    in_valid     = 1'b0;
    in_last_v    = 1'b0;
    out_ready    = '0;
    d3_in_data   = '0;
    d3_in_sel    = '0;
    d3_in_valid  = 1'b0;
    d3_out_ready = '0;
`ifdef DEMUX_PKT_LOCK_EN
    d3_in_last   = 1'b1;
`endif
    test_reset();
    test_stream();
    test_stall();
    test_bad_sel();
    test_reset_mid();
    test_back_to_back();
`ifdef DEMUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
